// File: rtl/cache_register_file_if.sv
// Write/read bus of cache_register_file: one write port, two registered read ports.
interface cache_register_file_if #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              WE;
  logic [1:0]        WMODE;
  logic [ADDR_W-1:0] WADDR;
  logic [WIDTH-1:0]  WDATA;
  logic              RE_A;
  logic              RE_B;
  logic [ADDR_W-1:0] RADDR_A;
  logic [ADDR_W-1:0] RADDR_B;
  logic [WIDTH-1:0]  RDATA_A;
  logic [WIDTH-1:0]  RDATA_B;
  logic              RVALID_A;
  logic              RVALID_B;

  modport master (
    output WE, WMODE, WADDR, WDATA, RE_A, RE_B, RADDR_A, RADDR_B,
    input  RDATA_A, RDATA_B, RVALID_A, RVALID_B
  );

  modport slave (
    input  WE, WMODE, WADDR, WDATA, RE_A, RE_B, RADDR_A, RADDR_B,
    output RDATA_A, RDATA_B, RVALID_A, RVALID_B
  );
endinterface

// File: rtl/cache_register_file.sv
// Multi-entry operand/result store: one load/RMW write port, two registered
// write-first read ports, per-entry valid tracking.
module cache_register_file #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  cache_register_file_if.slave  bus
);

  typedef enum logic [1:0] {
    WM_LOAD = 2'd0,
    WM_AND  = 2'd1,
    WM_OR   = 2'd2,
    WM_XOR  = 2'd3
  } wmode_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] new_val;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic             rvalid_a, rvalid_b;
  logic             byp_a, byp_b;

  // An invalid entry is treated as zero for read-modify-write.
  always_comb begin
    old_val = valid[bus.WADDR] ? mem[bus.WADDR] : '0;
    new_val = bus.WDATA;
    unique case (wmode_e'(bus.WMODE))
      WM_LOAD: new_val = bus.WDATA;
      WM_AND:  new_val = old_val & bus.WDATA;
      WM_OR:   new_val = old_val | bus.WDATA;
      WM_XOR:  new_val = old_val ^ bus.WDATA;
      default: new_val = bus.WDATA;
    endcase
  end

  always_comb begin
    byp_a = bus.WE && (bus.RADDR_A == bus.WADDR);
    byp_b = bus.WE && (bus.RADDR_B == bus.WADDR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem      <= '{default: '0};
      valid    <= '0;
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      if (bus.WE) begin
        mem[bus.WADDR]   <= new_val;
        valid[bus.WADDR] <= 1'b1;
      end
      if (bus.RE_A) begin
        rdata_a  <= byp_a ? new_val : mem[bus.RADDR_A];
        rvalid_a <= byp_a ? 1'b1    : valid[bus.RADDR_A];
      end
      if (bus.RE_B) begin
        rdata_b  <= byp_b ? new_val : mem[bus.RADDR_B];
        rvalid_b <= byp_b ? 1'b1    : valid[bus.RADDR_B];
      end
    end
  end

  assign bus.RDATA_A  = rdata_a;
  assign bus.RDATA_B  = rdata_b;
  assign bus.RVALID_A = rvalid_a;
  assign bus.RVALID_B = rvalid_b;

endmodule

// File: tb/tb_cache_register_file.sv
// Self-checking bench for cache_register_file: directed scenarios plus random
// traffic against an array-based reference model.
module tb_cache_register_file;

  logic CLK = 1'b0;
  logic RST;

  cache_register_file_if #(.WIDTH(16), .DEPTH(8)) bus ();

  cache_register_file #(.WIDTH(16), .DEPTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [15:0] m_mem [8];
  bit          m_val [8];
  logic [15:0] exp_da, exp_db;
  bit          exp_va, exp_vb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] apply_mode(input logic [1:0] md, input logic [15:0] old,
                                             input logic [15:0] wd);
    case (md)
      2'd0:    return wd;
      2'd1:    return old & wd;
      2'd2:    return old | wd;
      default: return old ^ wd;
    endcase
  endfunction

  // One clock of traffic; model updated from its pre-edge state, outputs checked #1 after the edge.
  task automatic step(input bit rst, input bit we, input logic [1:0] md, input logic [2:0] wa,
                      input logic [15:0] wd, input bit rea, input logic [2:0] ra,
                      input bit reb, input logic [2:0] rb);
    logic [15:0] nv;
    RST         = rst;
    bus.WE      = we;
    bus.WMODE   = md;
    bus.WADDR   = wa;
    bus.WDATA   = wd;
    bus.RE_A    = rea;
    bus.RADDR_A = ra;
    bus.RE_B    = reb;
    bus.RADDR_B = rb;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i] = '0;
        m_val[i] = 1'b0;
      end
      exp_da = '0; exp_db = '0; exp_va = 1'b0; exp_vb = 1'b0;
    end else begin
      nv = apply_mode(md, m_val[wa] ? m_mem[wa] : 16'h0000, wd);
      if (rea) begin
        exp_da = (we && ra == wa) ? nv : (m_val[ra] ? m_mem[ra] : 16'h0000);
        exp_va = (we && ra == wa) ? 1'b1 : m_val[ra];
      end
      if (reb) begin
        exp_db = (we && rb == wa) ? nv : (m_val[rb] ? m_mem[rb] : 16'h0000);
        exp_vb = (we && rb == wa) ? 1'b1 : m_val[rb];
      end
      if (we) begin
        m_mem[wa] = nv;
        m_val[wa] = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
    check_eq("rdata_a",  32'(bus.RDATA_A),  32'(exp_da));
    check_eq("rvalid_a", 32'(bus.RVALID_A), 32'(exp_va));
    check_eq("rdata_b",  32'(bus.RDATA_B),  32'(exp_db));
    check_eq("rvalid_b", 32'(bus.RVALID_B), 32'(exp_vb));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    logic [1:0]  md;
    logic [2:0]  wa, ra, rb;
    logic [15:0] wd;
    bit          r, we, rea, reb;

    RST = 1'b1;
    bus.WE = 1'b0; bus.WMODE = 2'd0; bus.WADDR = '0; bus.WDATA = '0;
    bus.RE_A = 1'b0; bus.RADDR_A = '0; bus.RE_B = 1'b0; bus.RADDR_B = '0;
    #2;

    // Reset state
    step(1'b1, 1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
    check_eq("reset_rdata_a", 32'(bus.RDATA_A), 32'h0);

    // Fill all, reset, read all back on both ports
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 2'd0, 3'(i), 16'h1111 * 16'(i + 1), 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 2'd0, 3'd0, 16'h0000, 1'b1, 3'(i), 1'b1, 3'(7 - i));
      check_eq("post_reset_a", {15'h0, bus.RVALID_A, bus.RDATA_A}, 32'h0);
      check_eq("post_reset_b", {15'h0, bus.RVALID_B, bus.RDATA_B}, 32'h0);
    end

    // Load / read, plus invalid read on B
    step(1'b0, 1'b1, 2'd0, 3'd3, 16'hA5A5, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 2'd0, 3'd0, 16'h0000, 1'b1, 3'd3, 1'b1, 3'd4);
    check_eq("load_a", {15'h0, bus.RVALID_A, bus.RDATA_A}, 32'h1_A5A5);
    check_eq("inval_b", {15'h0, bus.RVALID_B, bus.RDATA_B}, 32'h0);

    // RMW chain on addr 2
    step(1'b0, 1'b1, 2'd0, 3'd2, 16'h00FF, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 2'd2, 3'd2, 16'h0F00, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 2'd1, 3'd2, 16'h0FF0, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 2'd3, 3'd2, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 2'd0, 3'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 3'd0);
    check_eq("rmw_chain", 32'(bus.RDATA_A), 32'h0000_F00F);

    // RMW on never-written entry
    step(1'b0, 1'b1, 2'd3, 3'd5, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 2'd0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1, 3'd5);
    check_eq("rmw_invalid", {15'h0, bus.RVALID_B, bus.RDATA_B}, 32'h1_1234);

    // Write-first bypass on both ports, then hold with RE low
    step(1'b0, 1'b1, 2'd0, 3'd1, 16'hBEEF, 1'b1, 3'd1, 1'b1, 3'd1);
    check_eq("bypass_a", {15'h0, bus.RVALID_A, bus.RDATA_A}, 32'h1_BEEF);
    check_eq("bypass_b", {15'h0, bus.RVALID_B, bus.RDATA_B}, 32'h1_BEEF);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 1'b0, 3'd1, 1'b0, 3'd1);
    check_eq("hold_a", 32'(bus.RDATA_A), 32'h0000_BEEF);

    // Reset during write
    step(1'b1, 1'b1, 2'd0, 3'd0, 16'h7777, 1'b1, 3'd0, 1'b1, 3'd0);
    step(1'b0, 1'b0, 2'd0, 3'd0, 16'h0000, 1'b1, 3'd0, 1'b0, 3'd0);
    check_eq("rst_write", {15'h0, bus.RVALID_A, bus.RDATA_A}, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 59) == 0);
      we  = $urandom_range(0, 3) != 0;
      md  = 2'($urandom_range(0, 3));
      wa  = 3'($urandom_range(0, 7));
      wd  = 16'($urandom);
      rea = $urandom_range(0, 3) != 0;
      reb = $urandom_range(0, 3) != 0;
      ra  = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      rb  = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      step(r, we, md, wa, wd, rea, ra, reb, rb);
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
